// File: rtl/range_stats_pkg.sv
// range_stats_pkg
//   Shared types and defaults for the range_stats streaming min/max/range tracker.
//   - state_t      : run-control FSM states
//   - DEFAULT_W    : default sample width
//   - DEFAULT_CNT_W: default sample counter width
//   - MODE_MIN/MAX : selects which extreme an extreme_reg instance tracks
package range_stats_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READING = 2'd1,
    FINISH  = 2'd2,
    ERROR   = 2'd3
  } state_t;

  localparam int DEFAULT_W     = 10;
  localparam int DEFAULT_CNT_W = 8;

  localparam bit MODE_MIN = 1'b0;
  localparam bit MODE_MAX = 1'b1;

endpackage : range_stats_pkg

// File: rtl/range_stats_extreme_reg.sv
// extreme_reg
//   Holds one running extreme (minimum or maximum) of a sample stream.
//   Ports:
//     clock   in  1  clock, all updates on posedge
//     reset   in  1  synchronous active-high reset, clears value
//     clear   in  1  synchronous clear to 0 (takes priority over seed/update)
//     seed    in  1  load data_in unconditionally (first sample of a run)
//     update  in  1  load data_in only if it is a strictly better extreme
//     data_in in  W  unsigned sample
//     value   out W  current extreme
//   Parameters: W (sample width), MODE (MODE_MIN or MODE_MAX).
module extreme_reg
  import range_stats_pkg::*;
#(
  parameter int W    = DEFAULT_W,
  parameter bit MODE = MODE_MIN
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         seed,
  input  logic         update,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] value
);

  logic [W-1:0] value_reg;
  logic         better;

  // Strict comparison: equal samples never reload the register.
  always_comb begin
    if (MODE == MODE_MAX) begin
      better = (data_in > value_reg);
    end else begin
      better = (data_in < value_reg);
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      value_reg <= '0;
    end else if (seed) begin
      value_reg <= data_in;
    end else if (update && better) begin
      value_reg <= data_in;
    end
  end

  assign value = value_reg;

endmodule : extreme_reg

// File: rtl/range_stats.sv
// range_stats
//   Streaming min/max/range/count tracker. Between go and finish, valid-qualified
//   samples are accepted; the first sample of a run seeds both min and max.
//   Results hold after finish until the next go.
//   Optional feature macro: RANGE_STATS_SUM_EN adds sum_out, a saturating running
//   sum of the accepted samples.
//   Ports:
//     clock     in  1      clock
//     reset     in  1      synchronous active-high reset
//     data_in   in  W      unsigned sample
//     valid_in  in  1      data_in holds a sample this cycle
//     go        in  1      start a run
//     finish    in  1      end a run
//     min_out   out W      running/final minimum
//     max_out   out W      running/final maximum
//     range_out out W      max_out - min_out
//     count_out out CNT_W  accepted samples this run (saturating)
//     done      out 1      high in FINISH
//     error     out 1      high in ERROR
//     sum_out   out W+CNT_W  (RANGE_STATS_SUM_EN only) saturating sum of samples
module range_stats
  import range_stats_pkg::*;
#(
  parameter int W     = DEFAULT_W,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [W-1:0]     data_in,
  input  logic             valid_in,
  input  logic             go,
  input  logic             finish,
  output logic [W-1:0]     min_out,
  output logic [W-1:0]     max_out,
  output logic [W-1:0]     range_out,
  output logic [CNT_W-1:0] count_out,
  output logic             done,
  output logic             error
`ifdef RANGE_STATS_SUM_EN
  ,
  output logic [W+CNT_W-1:0] sum_out
`endif
);

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] count_reg;
  logic             seeded_reg;

  logic accept;
  logic start_run;
  logic clear_stats;
  logic seed;
  logic update;
  logic count_sat;

  assign accept      = (state_reg == READING) && valid_in;
  assign start_run   = (state_reg != READING) && (state_next == READING);
  // Statistics are zeroed on entry to, and while in, ERROR.
  assign clear_stats = (state_next == ERROR);
  assign seed        = accept && !seeded_reg;
  assign update      = accept && seeded_reg;
  assign count_sat   = (count_reg == {CNT_W{1'b1}});

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (finish) begin
          state_next = ERROR;
        end else if (go) begin
          state_next = READING;
        end
      end
      READING: begin
        // A run must contain at least one sample, counting one arriving
        // in the finish cycle itself.
        if (finish) begin
          state_next = (accept || (count_reg != '0)) ? FINISH : ERROR;
        end
      end
      FINISH: begin
        if (!finish) begin
          state_next = go ? READING : IDLE;
        end
      end
      ERROR: begin
        if (go && !finish) begin
          state_next = READING;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    done  = (state_reg == FINISH);
    error = (state_reg == ERROR);
  end

  // ---------------- counter and seed flag ----------------
  always_ff @(posedge clock) begin
    if (reset || clear_stats || start_run) begin
      count_reg  <= '0;
      seeded_reg <= 1'b0;
    end else if (accept) begin
      seeded_reg <= 1'b1;
      if (!seeded_reg) begin
        count_reg <= {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (!count_sat) begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

  // ---------------- extremes: index 0 = min, 1 = max ----------------
  logic [W-1:0] ext_val [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ext
      extreme_reg #(
        .W    (W),
        .MODE ((gi == 1) ? MODE_MAX : MODE_MIN)
      ) u_ext (
        .clock   (clock),
        .reset   (reset),
        .clear   (clear_stats),
        .seed    (seed),
        .update  (update),
        .data_in (data_in),
        .value   (ext_val[gi])
      );
    end
  endgenerate

  assign min_out   = ext_val[0];
  assign max_out   = ext_val[1];
  // min <= max always holds: both are seeded together and cleared together.
  assign range_out = ext_val[1] - ext_val[0];
  assign count_out = count_reg;

`ifdef RANGE_STATS_SUM_EN
  localparam int SW = W + CNT_W;

  logic [SW-1:0] sum_reg;
  logic [SW:0]   sum_wide;

  assign sum_wide = {1'b0, sum_reg} + {{(SW+1-W){1'b0}}, data_in};

  always_ff @(posedge clock) begin
    if (reset || clear_stats || start_run) begin
      sum_reg <= '0;
    end else if (seed) begin
      sum_reg <= {{(SW-W){1'b0}}, data_in};
    end else if (update) begin
      sum_reg <= sum_wide[SW] ? {SW{1'b1}} : sum_wide[SW-1:0];
    end
  end

  assign sum_out = sum_reg;
`endif

endmodule : range_stats

// File: tb/tb_range_stats.sv
// tb_range_stats
//   Table-driven bench for range_stats (W=10, CNT_W=3). Each table row is one
//   clock cycle of stimulus plus the outputs expected after that edge; expected
//   records go through a scoreboard queue and are compared #1 after the edge.
module tb_range_stats;
  import range_stats_pkg::*;

  localparam int W     = 10;
  localparam int CNT_W = 3;

  logic             clock;
  logic             reset;
  logic [W-1:0]     data_in;
  logic             valid_in;
  logic             go;
  logic             finish;
  logic [W-1:0]     min_out;
  logic [W-1:0]     max_out;
  logic [W-1:0]     range_out;
  logic [CNT_W-1:0] count_out;
  logic             done;
  logic             error;
`ifdef RANGE_STATS_SUM_EN
  logic [W+CNT_W-1:0] sum_out;
`endif

  range_stats #(.W(W), .CNT_W(CNT_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .go        (go),
    .finish    (finish),
    .min_out   (min_out),
    .max_out   (max_out),
    .range_out (range_out),
    .count_out (count_out),
    .done      (done),
    .error     (error)
`ifdef RANGE_STATS_SUM_EN
    ,
    .sum_out   (sum_out)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int rst, g, fin, vld, data;
    int chk;
    int emin, emax, erng, ecnt, edone, eerr;
    int schk, esum;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(int rst, int g, int fin, int vld, int data, int chk,
                              int emin, int emax, int erng, int ecnt, int edone,
                              int eerr, int schk, int esum);
    vec_t v;
    v.rst = rst; v.g = g; v.fin = fin; v.vld = vld; v.data = data; v.chk = chk;
    v.emin = emin; v.emax = emax; v.erng = erng; v.ecnt = ecnt;
    v.edone = edone; v.eerr = eerr; v.schk = schk; v.esum = esum;
    return v;
  endfunction

  task automatic cmp(input int idx, input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL txn %0d %s: got %0d expected %0d", idx, name, act, exp);
    end
  endtask

  initial begin
    //                 rst go fin vld data chk  min  max  rng cnt dn er schk sum
    // reset state
    vecs.push_back(mk(1, 0, 0, 0,    0, 1,    0,   0,   0, 0, 0, 0, 0,    0));
    // basic run: 300,120,900,450
    vecs.push_back(mk(0, 1, 0, 0,    0, 1,    0,   0,   0, 0, 0, 0, 0,    0));
    vecs.push_back(mk(0, 0, 0, 1,  300, 1,  300, 300,   0, 1, 0, 0, 0,    0));
    vecs.push_back(mk(0, 0, 0, 1,  120, 1,  120, 300, 180, 2, 0, 0, 0,    0));
    vecs.push_back(mk(0, 0, 0, 1,  900, 1,  120, 900, 780, 3, 0, 0, 0,    0));
    vecs.push_back(mk(0, 0, 0, 1,  450, 1,  120, 900, 780, 4, 0, 0, 0,    0));
    vecs.push_back(mk(0, 0, 1, 0,    0, 1,  120, 900, 780, 4, 1, 0, 0,    0));
    vecs.push_back(mk(0, 0, 0, 0,    0, 1,  120, 900, 780, 4, 0, 0, 0,    0));
    // go & finish in IDLE -> ERROR, stays, then go -> READING
    vecs.push_back(mk(0, 1, 1, 0,    0, 1,    0,   0,   0, 0, 0, 1, 0,    0));
    vecs.push_back(mk(0, 0, 0, 1,   77, 1,    0,   0,   0, 0, 0, 1, 0,    0));
    vecs.push_back(mk(0, 1, 0, 0,    0, 1,    0,   0,   0, 0, 0, 0, 0,    0));
    // empty run: finish with no samples -> ERROR
    vecs.push_back(mk(0, 0, 0, 0,    0, 1,    0,   0,   0, 0, 0, 0, 0,    0));
    vecs.push_back(mk(0, 0, 1, 0,    0, 1,    0,   0,   0, 0, 0, 1, 0,    0));
    vecs.push_back(mk(0, 1, 0, 0,    0, 1,    0,   0,   0, 0, 0, 0, 0,    0));
    // ten samples of 5, counter saturates at 7; go mid-run ignored
    for (int i = 1; i <= 10; i++) begin
      vecs.push_back(mk(0, (i == 3) ? 1 : 0, 0, 1, 5, 1, 5, 5, 0, (i > 7) ? 7 : i, 0, 0, 0, 0));
    end
    // sample 9 in the finish cycle is included
    vecs.push_back(mk(0, 0, 1, 1,    9, 1,    5,   9,   4, 7, 1, 0, 0,    0));
    // FINISH with finish held: frozen, valid ignored
    vecs.push_back(mk(0, 0, 1, 1, 1000, 1,    5,   9,   4, 7, 1, 0, 0,    0));
    // -> IDLE, results hold, valid ignored
    vecs.push_back(mk(0, 0, 0, 0,    0, 1,    5,   9,   4, 7, 0, 0, 0,    0));
    vecs.push_back(mk(0, 0, 0, 1,    0, 1,    5,   9,   4, 7, 0, 0, 0,    0));
    // single sample arriving in the finish cycle
    vecs.push_back(mk(0, 1, 0, 0,    0, 0,    0,   0,   0, 0, 0, 0, 0,    0));
    vecs.push_back(mk(0, 0, 1, 1,   33, 1,   33,  33,   0, 1, 1, 0, 0,    0));
    vecs.push_back(mk(0, 0, 0, 0,    0, 1,   33,  33,   0, 1, 0, 0, 0,    0));
    // reset mid-run with gaps in valid_in
    vecs.push_back(mk(0, 1, 0, 0,    0, 0,    0,   0,   0, 0, 0, 0, 0,    0));
    vecs.push_back(mk(0, 0, 0, 1,   50, 1,   50,  50,   0, 1, 0, 0, 0,    0));
    vecs.push_back(mk(0, 0, 0, 0,  999, 1,   50,  50,   0, 1, 0, 0, 0,    0));
    vecs.push_back(mk(0, 0, 0, 1,   60, 1,   50,  60,  10, 2, 0, 0, 0,    0));
    vecs.push_back(mk(0, 0, 0, 0,    0, 1,   50,  60,  10, 2, 0, 0, 0,    0));
    vecs.push_back(mk(1, 1, 0, 1,   70, 1,    0,   0,   0, 0, 0, 0, 0,    0));
    vecs.push_back(mk(0, 0, 0, 0,    0, 1,    0,   0,   0, 0, 0, 0, 0,    0));
    // run 1: 1023,1023,2; then FINISH -> go straight into run 2 with 7
    vecs.push_back(mk(0, 1, 0, 0,    0, 1,    0,   0,   0, 0, 0, 0, 1,    0));
    vecs.push_back(mk(0, 0, 0, 1, 1023, 1, 1023,1023,   0, 1, 0, 0, 1, 1023));
    vecs.push_back(mk(0, 0, 0, 1, 1023, 1, 1023,1023,   0, 2, 0, 0, 1, 2046));
    vecs.push_back(mk(0, 0, 0, 1,    2, 1,    2,1023,1021, 3, 0, 0, 1, 2048));
    vecs.push_back(mk(0, 0, 1, 0,    0, 1,    2,1023,1021, 3, 1, 0, 1, 2048));
    vecs.push_back(mk(0, 1, 0, 0,    0, 1,    2,1023,1021, 0, 0, 0, 1,    0));
    vecs.push_back(mk(0, 0, 0, 1,    7, 1,    7,   7,   0, 1, 0, 0, 1,    7));
    vecs.push_back(mk(0, 0, 1, 0,    0, 1,    7,   7,   0, 1, 1, 0, 1,    7));

    reset = 1'b1; go = 1'b0; finish = 1'b0; valid_in = 1'b0; data_in = '0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      reset    = vecs[i].rst[0];
      go       = vecs[i].g[0];
      finish   = vecs[i].fin[0];
      valid_in = vecs[i].vld[0];
      data_in  = vecs[i].data[W-1:0];
      if (vecs[i].chk != 0) exp_q.push_back(vecs[i]);
      @(posedge clock);
      #1;
      if (vecs[i].chk != 0) begin
        vec_t e;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL txn %0d scoreboard: got empty queue expected 1 entry", i);
        end else begin
          e = exp_q.pop_front();
          $display("txn %0d: min=%0d max=%0d range=%0d count=%0d done=%0d error=%0d",
                   i, min_out, max_out, range_out, count_out, done, error);
          cmp(i, "min_out",   int'(min_out),   e.emin);
          cmp(i, "max_out",   int'(max_out),   e.emax);
          cmp(i, "range_out", int'(range_out), e.erng);
          cmp(i, "count_out", int'(count_out), e.ecnt);
          cmp(i, "done",      int'(done),      e.edone);
          cmp(i, "error",     int'(error),     e.eerr);
`ifdef RANGE_STATS_SUM_EN
          if (e.schk != 0) cmp(i, "sum_out", int'(sum_out), e.esum);
`endif
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_range_stats
